// File: rtl/hex_sector_shader_if.sv
// Pixel/palette/rotation bundle between the hex coordinate generator and the shader.
// Latency: none (wiring only).
// Backpressure: none; the shader accepts one pixel per cycle unconditionally.
interface hex_sector_shader_if #(
  parameter int COLOUR_W = 4,
  parameter int RADIUS_W = 10
);
  logic                    in_valid;
  logic [2:0]              quadrant;
  logic [RADIUS_W-1:0]     radius;
  logic                    frame_start;
  logic [7:0]              rot_period;
  logic                    rot_dir;
  logic                    pal_we;
  logic [2:0]              pal_addr;
  logic [3*COLOUR_W-1:0]   pal_data;
  logic                    out_valid;
  logic [COLOUR_W-1:0]     red;
  logic [COLOUR_W-1:0]     green;
  logic [COLOUR_W-1:0]     blue;

  modport master (
    output in_valid, quadrant, radius, frame_start, rot_period, rot_dir,
           pal_we, pal_addr, pal_data,
    input  out_valid, red, green, blue
  );

  modport slave (
    input  in_valid, quadrant, radius, frame_start, rot_period, rot_dir,
           pal_we, pal_addr, pal_data,
    output out_valid, red, green, blue
  );
endinterface

// File: rtl/hex_sector_shader.sv
// Maps (sector, radius) to RGB via a writable rotating palette with radial stripe shading.
// Latency: 2 cycles input to output, 1 pixel per cycle.
// Backpressure: none; never stalls, blanked or out-of-range pixels come out black.
module hex_sector_shader #(
  parameter int COLOUR_W    = 4,
  parameter int RADIUS_W    = 10,
  parameter int NUM_SECTORS = 6,
  parameter int STRIPE_BIT  = 4
) (
  input logic               clk,
  input logic               rst_n,
  hex_sector_shader_if.slave bus
);
  localparam int PAL_W = 3 * COLOUR_W;

  // Power-on palette: red, yellow, green, cyan, blue, magenta, then black.
  function automatic logic [PAL_W-1:0] pal_default(input int idx);
    logic [COLOUR_W-1:0] m;
    logic [COLOUR_W-1:0] z;
    m = '1;
    z = '0;
    case (idx)
      0:       return {m, z, z};
      1:       return {m, m, z};
      2:       return {z, m, z};
      3:       return {z, m, m};
      4:       return {z, z, m};
      5:       return {m, z, m};
      default: return {z, z, z};
    endcase
  endfunction

  logic [PAL_W-1:0]    pal_q [8];
  logic [7:0]          frame_cnt_q, frame_cnt_d;
  logic [2:0]          offset_q, offset_d;

  logic                s1_vld_q, s1_oor_q, s1_stripe_q;
  logic [PAL_W-1:0]    s1_pal_q;
  logic [3:0]          sect_sum;
  logic [3:0]          sect_eff;

  logic                out_vld_q;
  logic [COLOUR_W-1:0] red_q, green_q, blue_q;
  logic [COLOUR_W-1:0] red_d, green_d, blue_d;

  // Only the stripe bit of the radius matters; the rest is folded away here.
  logic unused_radius;
  assign unused_radius = ^bus.radius;

  // Palette storage: writes land at the edge, so a same-cycle read sees the old entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) pal_q[i] <= pal_default(i);
    end else if (bus.pal_we) begin
      pal_q[bus.pal_addr] <= bus.pal_data;
    end
  end

  // Rotation next state; >= compare means a shortened period steps at once instead of stalling.
  always_comb begin
    frame_cnt_d = frame_cnt_q;
    offset_d    = offset_q;
    if (bus.rot_period == 8'd0) begin
      frame_cnt_d = 8'd0;
    end else if (bus.frame_start) begin
      if (({1'b0, frame_cnt_q} + 9'd1) >= {1'b0, bus.rot_period}) begin
        frame_cnt_d = 8'd0;
        if (bus.rot_dir)
          offset_d = (offset_q == 3'd0) ? 3'(NUM_SECTORS - 1) : offset_q - 3'd1;
        else
          offset_d = (offset_q == 3'(NUM_SECTORS - 1)) ? 3'd0 : offset_q + 3'd1;
      end else begin
        frame_cnt_d = frame_cnt_q + 8'd1;
      end
    end
  end

  // Rotation state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt_q <= 8'd0;
      offset_q    <= 3'd0;
    end else begin
      frame_cnt_q <= frame_cnt_d;
      offset_q    <= offset_d;
    end
  end

  // Effective sector: one conditional subtract suffices since both terms are below NUM_SECTORS.
  always_comb begin
    sect_sum = {1'b0, bus.quadrant} + {1'b0, offset_q};
    sect_eff = (sect_sum >= 4'(NUM_SECTORS)) ? sect_sum - 4'(NUM_SECTORS) : sect_sum;
  end

  // Stage 1: capture valid, range flag, stripe bit and the selected palette entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld_q    <= 1'b0;
      s1_oor_q    <= 1'b0;
      s1_stripe_q <= 1'b0;
      s1_pal_q    <= '0;
    end else begin
      s1_vld_q    <= bus.in_valid;
      s1_oor_q    <= ({1'b0, bus.quadrant} >= 4'(NUM_SECTORS));
      s1_stripe_q <= bus.radius[STRIPE_BIT];
      s1_pal_q    <= pal_q[sect_eff[2:0]];
    end
  end

  // Stage 2 colour: halve each channel on stripes, force black when blanked or out of range.
  always_comb begin
    red_d   = s1_pal_q[3*COLOUR_W-1 -: COLOUR_W];
    green_d = s1_pal_q[2*COLOUR_W-1 -: COLOUR_W];
    blue_d  = s1_pal_q[COLOUR_W-1   -: COLOUR_W];
    if (s1_stripe_q) begin
      red_d   = red_d   >> 1;
      green_d = green_d >> 1;
      blue_d  = blue_d  >> 1;
    end
    if (!s1_vld_q || s1_oor_q) begin
      red_d   = '0;
      green_d = '0;
      blue_d  = '0;
    end
  end

  // Stage 2 output register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_vld_q <= 1'b0;
      red_q     <= '0;
      green_q   <= '0;
      blue_q    <= '0;
    end else begin
      out_vld_q <= s1_vld_q;
      red_q     <= red_d;
      green_q   <= green_d;
      blue_q    <= blue_d;
    end
  end

  assign bus.out_valid = out_vld_q;
  assign bus.red       = red_q;
  assign bus.green     = green_q;
  assign bus.blue      = blue_q;
endmodule
